// File: rtl/ibex_pkg.sv
// Shared types and exception-code constants for the interrupt arbiter.
package ibex_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_OFFER   = 2'd1,
    IRQ_HOLDOFF = 2'd2
  } irq_arb_state_e;

  localparam logic [4:0] IRQ_CODE_EXT       = 5'd11;
  localparam logic [4:0] IRQ_CODE_SW        = 5'd3;
  localparam logic [4:0] IRQ_CODE_TIMER     = 5'd7;
  localparam logic [4:0] IRQ_CODE_FAST_BASE = 5'd16;
  localparam logic [4:0] IRQ_CODE_NMI       = 5'd31;

  localparam int IRQ_HOLD_W = 4;
  localparam int IRQ_LAT_W  = 16;

endpackage

// File: rtl/ibex_irq_prio_enc.sv
// Combinational fixed-priority pick: NMI > fast[0..N-1] > external > software > timer.
module ibex_irq_prio_enc
  import ibex_pkg::*;
#(
  parameter int NumFastIrqs = 15
) (
  input  logic                   i_nmi,
  input  logic [NumFastIrqs-1:0] i_fast,
  input  logic                   i_ext,
  input  logic                   i_sw,
  input  logic                   i_tmr,
  output logic                   o_valid,
  output logic [4:0]             o_cause,
  output logic                   o_nmi
);

  // Scan lowest priority first so each higher source overrides.
  always_comb begin
    o_valid = 1'b0;
    o_cause = '0;
    o_nmi   = 1'b0;
    if (i_tmr) begin o_valid = 1'b1; o_cause = IRQ_CODE_TIMER; end
    if (i_sw)  begin o_valid = 1'b1; o_cause = IRQ_CODE_SW;    end
    if (i_ext) begin o_valid = 1'b1; o_cause = IRQ_CODE_EXT;   end
    for (int i = NumFastIrqs - 1; i >= 0; i--) begin
      if (i_fast[i]) begin
        o_valid = 1'b1;
        o_cause = IRQ_CODE_FAST_BASE + 5'(i);
      end
    end
    if (i_nmi) begin
      o_valid = 1'b1;
      o_cause = IRQ_CODE_NMI;
      o_nmi   = 1'b1;
    end
  end

endmodule

// File: rtl/ibex_irq_arbiter.sv
// Interrupt arbiter: offers one interrupt at a time, holds it until ack, then holds off.
// Optional IBEX_IRQ_ARB_LATENCY_EN adds lat_max_o (max OFFER-to-ack cycles).
module ibex_irq_arbiter
  import ibex_pkg::*;
#(
  parameter int NumFastIrqs   = 15,
  parameter int HoldoffCycles = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   irq_software_i,
  input  logic                   irq_timer_i,
  input  logic                   irq_external_i,
  input  logic [NumFastIrqs-1:0] irq_fast_i,
  input  logic                   irq_nm_i,
  input  logic                   global_en_i,
  input  logic                   debug_mode_i,
  input  logic                   nmi_mode_i,
  output logic                   req_o,
  output logic [4:0]             cause_o,
  output logic                   nmi_o,
  input  logic                   ack_i
`ifdef IBEX_IRQ_ARB_LATENCY_EN
  ,
  output logic [IRQ_LAT_W-1:0]   lat_max_o
`endif
);

  irq_arb_state_e        r_state;
  logic                  r_req, r_nmi;
  logic [4:0]            r_cause;
  logic [IRQ_HOLD_W-1:0] r_cnt;
  logic                  r_nm_q, r_nm_block, r_nmi_pend;

  logic                   w_nm_edge, w_mask_en, w_nmi_elig, w_nmi_clr, w_still;
  logic                   w_sel_valid, w_sel_nmi;
  logic [4:0]             w_sel_cause;
  logic [NumFastIrqs-1:0] w_fast_elig;
  logic [31:0]            w_elig_code;

  // r_nm_block is loaded during reset so a level held through reset is not an edge.
  assign w_nm_edge   = irq_nm_i & ~r_nm_q & ~r_nm_block;
  assign w_mask_en   = global_en_i & ~debug_mode_i & ~nmi_mode_i;
  assign w_nmi_elig  = (r_nmi_pend | w_nm_edge) & ~debug_mode_i & ~nmi_mode_i;
  assign w_fast_elig = irq_fast_i & {NumFastIrqs{w_mask_en}};
  assign w_nmi_clr   = (r_state == IRQ_OFFER) & ack_i & r_nmi;

  // Eligibility indexed by exception code, used to detect withdrawal of the held offer.
  always_comb begin
    w_elig_code = '0;
    w_elig_code[IRQ_CODE_EXT]   = w_mask_en & irq_external_i;
    w_elig_code[IRQ_CODE_SW]    = w_mask_en & irq_software_i;
    w_elig_code[IRQ_CODE_TIMER] = w_mask_en & irq_timer_i;
    for (int i = 0; i < NumFastIrqs; i++) begin
      w_elig_code[5'(IRQ_CODE_FAST_BASE + 5'(i))] = w_fast_elig[i];
    end
  end
  assign w_still = w_elig_code[r_cause];

  ibex_irq_prio_enc #(.NumFastIrqs(NumFastIrqs)) u_prio_enc (
    .i_nmi   (w_nmi_elig),
    .i_fast  (w_fast_elig),
    .i_ext   (w_elig_code[IRQ_CODE_EXT]),
    .i_sw    (w_elig_code[IRQ_CODE_SW]),
    .i_tmr   (w_elig_code[IRQ_CODE_TIMER]),
    .o_valid (w_sel_valid),
    .o_cause (w_sel_cause),
    .o_nmi   (w_sel_nmi)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_nm_q     <= 1'b0;
      r_nm_block <= irq_nm_i;
      r_nmi_pend <= 1'b0;
    end else begin
      r_nm_q     <= irq_nm_i;
      r_nm_block <= r_nm_block & irq_nm_i;
      r_nmi_pend <= (r_nmi_pend & ~w_nmi_clr) | w_nm_edge;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IRQ_IDLE;
      r_req   <= 1'b0;
      r_cause <= '0;
      r_nmi   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IRQ_IDLE: begin
          if (w_sel_valid) begin
            r_state <= IRQ_OFFER;
            r_req   <= 1'b1;
            r_cause <= w_sel_cause;
            r_nmi   <= w_sel_nmi;
          end
        end
        IRQ_OFFER: begin
          if (ack_i) begin
            r_req <= 1'b0;
            if (HoldoffCycles == 0) begin
              r_state <= IRQ_IDLE;
            end else begin
              r_state <= IRQ_HOLDOFF;
              r_cnt   <= IRQ_HOLD_W'(HoldoffCycles);
            end
          end else if (!r_nmi && !w_still) begin
            r_state <= IRQ_IDLE;
            r_req   <= 1'b0;
          end
        end
        IRQ_HOLDOFF: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt <= 1) r_state <= IRQ_IDLE;
        end
        default: begin
          r_state <= IRQ_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign req_o   = r_req;
  assign cause_o = r_cause;
  assign nmi_o   = r_nmi;

`ifdef IBEX_IRQ_ARB_LATENCY_EN
  logic [IRQ_LAT_W-1:0] r_lat_cnt, r_lat_max;
  logic [IRQ_LAT_W-1:0] w_lat_cur;

  // w_lat_cur counts the current cycle too, so an ack on the first offer cycle reads 1.
  assign w_lat_cur = (&r_lat_cnt) ? r_lat_cnt : r_lat_cnt + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lat_cnt <= '0;
      r_lat_max <= '0;
    end else if (r_state == IRQ_OFFER) begin
      r_lat_cnt <= w_lat_cur;
      if (ack_i) begin
        r_lat_cnt <= '0;
        if (w_lat_cur > r_lat_max) r_lat_max <= w_lat_cur;
      end
    end else begin
      r_lat_cnt <= '0;
    end
  end

  assign lat_max_o = r_lat_max;
`endif

endmodule

// File: doc/ibex_irq_arbiter.md
IBEX_IRQ_ARBITER -- requirements
Module: ibex_irq_arbiter

Interface
REQ-001 The block SHALL have parameter NumFastIrqs, default 15, the number of fast interrupt lines (1..15).
REQ-002 The block SHALL have parameter HoldoffCycles, default 2, the number of idle cycles after each ack before the next offer (0..15).
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  synchronous active-low reset.
REQ-006 irq_software_i / irq_timer_i / irq_external_i  in  1 each  level interrupts, already mie-qualified.
REQ-007 irq_fast_i  in  NumFastIrqs  level fast interrupts, already mie-qualified.
REQ-008 irq_nm_i  in  1  non-maskable interrupt, rising-edge sensitive.
REQ-009 global_en_i  in  1  mstatus.MIE or priv below M; gates maskable sources.
REQ-010 debug_mode_i / nmi_mode_i  in  1 each  core in debug mode / NMI handler.
REQ-011 req_o  out  1  offer of one interrupt to the controller.
REQ-012 cause_o  out  5  exception-code of the offered interrupt.
REQ-013 nmi_o  out  1  offered interrupt is the NMI.
REQ-014 ack_i  in  1  controller takes the offer; valid only while req_o=1.

Function
REQ-015 States SHALL be IDLE, OFFER, HOLDOFF.
REQ-016 Priority, highest first: NMI; irq_fast_i[0]..[NumFastIrqs-1]; external; software; timer.
REQ-017 Codes: fast[i]=16+i, external=11, software=3, timer=7, NMI=31 with nmi_o=1.
REQ-018 An NMI rising edge SHALL set a sticky nmi_pending flag that clears only on the ack of the NMI offer.
REQ-019 Eligible: nmi_pending when not debug_mode_i and not nmi_mode_i; maskable when global_en_i=1, debug_mode_i=0, nmi_mode_i=0.
REQ-020 IDLE->OFFER on the cycle after any eligible source is present, with the winner registered into cause_o/nmi_o (1-cycle latency from source to req_o).
REQ-021 In OFFER, req_o=1 and cause_o/nmi_o SHALL be held stable until ack_i or withdrawal; a newly arriving higher-priority source SHALL NOT change them.
REQ-022 Withdrawal: a maskable offer whose source drops or becomes ineligible without ack_i SHALL return to IDLE next cycle with req_o=0; an NMI offer SHALL never be withdrawn.
REQ-023 ack_i in OFFER -> HOLDOFF; counter loaded with HoldoffCycles; HoldoffCycles=0 goes directly to IDLE.
REQ-024 HOLDOFF decrements each cycle; at 0 -> IDLE; req_o=0 throughout; NMI edges are still captured.
REQ-025 Simultaneous ack_i and source drop in the same cycle SHALL count as ack.
REQ-026 ack_i outside OFFER SHALL be ignored.

Reset
REQ-027 rst_ni=0 at a clock edge SHALL force IDLE, req_o=0, cause_o=0, nmi_o=0, nmi_pending=0, counter=0, edge-detect register=0, including mid-offer.
REQ-028 An irq_nm_i held high through reset SHALL NOT generate an NMI edge after reset.

Configuration
REQ-029 Macro IBEX_IRQ_ARB_LATENCY_EN SHALL add output lat_max_o (16 bits): the maximum OFFER-to-ack cycle count seen since reset, saturating at 0xFFFF.
REQ-030 Without IBEX_IRQ_ARB_LATENCY_EN, the port and its counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-031 ibex_pkg SHALL hold the irq_arb_state_e enum and the cause-code constants (IRQ_CODE_EXT/SW/TIMER/FAST_BASE/NMI).
REQ-032 The priority selection SHALL be a combinational sub-module ibex_irq_prio_enc (inputs: eligible vectors; outputs: valid, cause, nmi).

Verification
REQ-033 irq_timer_i=1 and irq_external_i=1, global_en_i=1 -> req_o=1 one cycle later with cause_o=11; after ack, HOLDOFF 2 cycles, then cause_o=7.
REQ-034 irq_fast_i[3] and [5] asserted in OFFER (cause_o=3, software) -> cause_o stays 3 until ack; the next offer has cause_o=19.
REQ-035 irq_software_i drops before ack -> req_o=0 next cycle, state IDLE, no HOLDOFF.
REQ-036 irq_nm_i pulsed 1 cycle while nmi_mode_i=1 -> no offer; nmi_mode_i falls -> req_o=1, nmi_o=1, cause_o=31; global_en_i=0 does not block it.
REQ-037 rst_ni=0 mid-OFFER with irq_nm_i held high -> all outputs 0; no NMI offer after reset release.
REQ-038 With IBEX_IRQ_ARB_LATENCY_EN, acks after 4 and then 9 offer cycles -> lat_max_o=9.
